// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter that shares one APB completer among NUM_REQ requesters
// and turns each grant into a SETUP/ACCESS transfer with wait-state timeout.
module apb_req_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int TIMEOUT    = 15
) (
  input  logic                          pclk,
  input  logic                          presetn,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*WIDTH-1:0]      req_wdata,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            done,
  output logic [WIDTH-1:0]              rsp_rdata,
  output logic                          rsp_err,
  output logic                          psel,
  output logic                          penable,
  output logic                          pwrite,
  output logic [ADDR_WIDTH-1:0]         paddr,
  output logic [WIDTH-1:0]              pwdata,
  input  logic [WIDTH-1:0]              prdata,
  input  logic                          pready,
  input  logic                          pslverr
);

  localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNTW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNTW-1:0] TIMEOUT_CNT = CNTW'(TIMEOUT);
  localparam logic [IDXW-1:0] LAST_RST    = IDXW'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  state_e                 state_q;
  logic [IDXW-1:0]        last_q;
  logic [CNTW-1:0]        wait_cnt_q;
  logic [CNTW-1:0]        wait_cnt_d;
  logic [NUM_REQ-1:0]     gnt_q;
  logic [NUM_REQ-1:0]     done_q;
  logic                   psel_q;
  logic                   penable_q;
  logic                   pwrite_q;
  logic                   rsp_err_q;
  logic [ADDR_WIDTH-1:0]  paddr_q;
  logic [WIDTH-1:0]       pwdata_q;
  logic [WIDTH-1:0]       rsp_rdata_q;

  logic [NUM_REQ-1:0]     eligible;
  logic                   win_valid_d;
  logic [IDXW-1:0]        win_idx_d;
  logic [IDXW-1:0]        cand;
  logic                   win_write_d;
  logic [ADDR_WIDTH-1:0]  win_addr_d;
  logic [WIDTH-1:0]       win_wdata_d;
  logic                   timeout_hit;

  // A requester completing this cycle is held out for one arbitration so
  // it cannot be re-granted straight away while still holding req.
  assign eligible = req & ~done_q;

  always_comb begin
    win_valid_d = 1'b0;
    win_idx_d   = last_q;
    cand        = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDXW'((int'(last_q) + k) % NUM_REQ);
      if (!win_valid_d && eligible[cand]) begin
        win_valid_d = 1'b1;
        win_idx_d   = cand;
      end
    end
  end

  always_comb begin
    win_write_d = req_write[win_idx_d];
    win_addr_d  = req_addr[int'(win_idx_d)*ADDR_WIDTH +: ADDR_WIDTH];
    win_wdata_d = req_wdata[int'(win_idx_d)*WIDTH +: WIDTH];
  end

  assign wait_cnt_d  = (wait_cnt_q == '1) ? wait_cnt_q : wait_cnt_q + 1'b1;
  assign timeout_hit = (TIMEOUT != 0) && !pready && (wait_cnt_d == TIMEOUT_CNT);

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q     <= IDLE;
      last_q      <= LAST_RST;
      wait_cnt_q  <= '0;
      gnt_q       <= '0;
      done_q      <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      done_q <= '0;
      case (state_q)
        IDLE: begin
          if (win_valid_d) begin
            state_q    <= SETUP;
            psel_q     <= 1'b1;
            gnt_q      <= NUM_REQ'(1) << win_idx_d;
            last_q     <= win_idx_d;
            pwrite_q   <= win_write_d;
            paddr_q    <= win_addr_d;
            pwdata_q   <= win_wdata_d;
            wait_cnt_q <= '0;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          // A timed-out transfer reports an error with zeroed read data.
          if (pready || timeout_hit) begin
            state_q     <= IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            gnt_q       <= '0;
            done_q      <= gnt_q;
            rsp_err_q   <= pready ? pslverr : 1'b1;
            rsp_rdata_q <= (pready && !pwrite_q) ? prdata : '0;
          end else begin
            wait_cnt_q <= wait_cnt_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Bench for apb_req_arbiter: directed vector table, hand-written corner
// sequences and randomized request rounds scored by a transaction-level model.
module tb_apb_req_arbiter;

  localparam int NR = 3;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int TO = 4;

  logic              pclk;
  logic              presetn;
  logic [NR-1:0]     req;
  logic [NR-1:0]     reqWrite;
  logic [NR*AW-1:0]  reqAddr;
  logic [NR*DW-1:0]  reqWdata;
  logic [NR-1:0]     gnt;
  logic [NR-1:0]     done;
  logic [DW-1:0]     rspRdata;
  logic              rspErr;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [AW-1:0]     paddr;
  logic [DW-1:0]     pwdata;
  logic [DW-1:0]     prdata;
  logic              pready;
  logic              pslverr;

  int vectors;
  int miscompares;
  int modelLast;
  logic [31:0] mem [0:255];

  typedef struct {
    int          rq;
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    int          waits;
    logic        serr;
    logic [31:0] expRdata;
    logic        expErr;
    int          expLat;
  } vec_t;

  vec_t vecs [11];

  apb_req_arbiter #(
    .NUM_REQ    (NR),
    .WIDTH      (DW),
    .ADDR_WIDTH (AW),
    .TIMEOUT    (TO)
  ) dut (
    .pclk      (pclk),
    .presetn   (presetn),
    .req       (req),
    .req_write (reqWrite),
    .req_addr  (reqAddr),
    .req_wdata (reqWdata),
    .gnt       (gnt),
    .done      (done),
    .rsp_rdata (rspRdata),
    .rsp_err   (rspErr),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .prdata    (prdata),
    .pready    (pready),
    .pslverr   (pslverr)
  );

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%h, expected 0x%h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input int i, input logic wr, input logic [7:0] a, input logic [31:0] d);
    reqWrite[i]        = wr;
    reqAddr[i*AW +: AW] = a;
    reqWdata[i*DW +: DW] = d;
    req[i]             = 1'b1;
  endtask

  // Plays the completer for one transfer and checks the bus cycle by cycle.
  task automatic runTransfer(input int w, input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                             input int waits, input logic serr, input logic [31:0] expRdata,
                             input logic expErr, input int expGap, input logic scramble, output int lat);
    int gap;
    int acc;
    logic fin;
    logic [NR-1:0] oneHot;
    gap = 0;
    acc = 0;
    fin = 1'b0;
    lat = -1;
    oneHot = NR'(1) << w;
    do begin
      @(negedge pclk);
      gap++;
    end while (!psel && gap < 8);
    checkOutput("grantGap", gap, expGap);
    if (!psel) return;
    checkOutput("setupGnt", 32'(gnt), 32'(oneHot));
    checkOutput("setupEnable", 32'(penable), 32'd0);
    checkOutput("setupWrite", 32'(pwrite), 32'(wr));
    checkOutput("setupAddr", 32'(paddr), 32'(addr));
    checkOutput("setupWdata", pwdata, wd);
    pready  = 1'($urandom);
    pslverr = 1'($urandom);
    prdata  = $urandom;
    if (scramble) begin
      req[w]               = 1'b0;
      reqWrite[w]          = ~wr;
      reqAddr[w*AW +: AW]  = ~addr;
      reqWdata[w*DW +: DW] = ~wd;
    end
    while (!fin) begin
      @(negedge pclk);
      acc++;
      checkOutput("accessCtl", 32'({psel, penable}), 32'd3);
      checkOutput("accessGnt", 32'(gnt), 32'(oneHot));
      checkOutput("accessAddr", 32'(paddr), 32'(addr));
      checkOutput("accessWrite", 32'(pwrite), 32'(wr));
      checkOutput("accessWdata", pwdata, wd);
      checkOutput("accessDone", 32'(done), 32'd0);
      if (waits < TO && acc == waits + 1) begin
        pready  = 1'b1;
        pslverr = serr;
        prdata  = wr ? $urandom : mem[addr];
        if (wr && !serr) mem[addr] = wd;
        fin = 1'b1;
      end else begin
        pready  = 1'b0;
        pslverr = 1'($urandom);
        prdata  = $urandom;
        if (acc == TO) fin = 1'b1;
      end
    end
    @(negedge pclk);
    checkOutput("doneCtl", 32'({psel, penable}), 32'd0);
    checkOutput("doneGnt", 32'(gnt), 32'd0);
    checkOutput("donePulse", 32'(done), 32'(oneHot));
    checkOutput("rspErr", 32'(rspErr), 32'(expErr));
    checkOutput("rspRdata", rspRdata, expRdata);
    lat     = gap + acc + 1;
    pready  = 1'($urandom);
    pslverr = 1'($urandom);
    prdata  = $urandom;
  endtask

  initial begin
    int lat;
    vectors     = 0;
    miscompares = 0;
    modelLast   = NR - 1;
    for (int a = 0; a < 256; a++) mem[a] = 32'hA5A5_0000 | 32'(a);

    vecs[0]  = '{0, 1'b1, 8'h10, 32'hDEADBEEF, 0, 1'b0, 32'h0,        1'b0, 3};
    vecs[1]  = '{0, 1'b0, 8'h10, 32'h0,        0, 1'b0, 32'hDEADBEEF, 1'b0, 3};
    vecs[2]  = '{1, 1'b1, 8'h33, 32'h12345678, 2, 1'b0, 32'h0,        1'b0, 5};
    vecs[3]  = '{2, 1'b0, 8'h33, 32'h0,        0, 1'b0, 32'h12345678, 1'b0, 3};
    vecs[4]  = '{1, 1'b0, 8'h20, 32'h0,        0, 1'b1, 32'hA5A50020, 1'b1, 3};
    vecs[5]  = '{0, 1'b0, 8'h10, 32'h0,        0, 1'b0, 32'hDEADBEEF, 1'b0, 3};
    vecs[6]  = '{2, 1'b1, 8'h40, 32'hFFFF0000, 7, 1'b0, 32'h0,        1'b1, 6};
    vecs[7]  = '{1, 1'b0, 8'h33, 32'h0,        9, 1'b0, 32'h0,        1'b1, 6};
    vecs[8]  = '{0, 1'b0, 8'h40, 32'h0,        1, 1'b0, 32'hA5A50040, 1'b0, 4};
    vecs[9]  = '{2, 1'b1, 8'h20, 32'h13579BDF, 1, 1'b1, 32'h0,        1'b1, 4};
    vecs[10] = '{1, 1'b0, 8'h20, 32'h0,        3, 1'b0, 32'hA5A50020, 1'b0, 6};

    presetn  = 1'b0;
    req      = '0;
    reqWrite = '0;
    reqAddr  = '0;
    reqWdata = '0;
    prdata   = '0;
    pready   = 1'b0;
    pslverr  = 1'b0;
    #3;
    checkOutput("rstPsel", 32'(psel), 32'd0);
    checkOutput("rstPenable", 32'(penable), 32'd0);
    checkOutput("rstPwrite", 32'(pwrite), 32'd0);
    checkOutput("rstGnt", 32'(gnt), 32'd0);
    checkOutput("rstDone", 32'(done), 32'd0);
    checkOutput("rstErr", 32'(rspErr), 32'd0);
    checkOutput("rstPaddr", 32'(paddr), 32'd0);
    checkOutput("rstPwdata", pwdata, 32'd0);
    checkOutput("rstRdata", rspRdata, 32'd0);
    @(negedge pclk);
    presetn = 1'b1;

    // Two requesters held continuously must alternate, starting with 0.
    applyStimulus(0, 1'b1, 8'h50, 32'h11112222);
    applyStimulus(1, 1'b0, 8'h50, 32'h0);
    runTransfer(0, 1'b1, 8'h50, 32'h11112222, 0, 1'b0, 32'h0, 1'b0, 1, 1'b0, lat);
    runTransfer(1, 1'b0, 8'h50, 32'h0, 0, 1'b0, 32'h11112222, 1'b0, 1, 1'b0, lat);
    runTransfer(0, 1'b1, 8'h50, 32'h11112222, 1, 1'b0, 32'h0, 1'b0, 1, 1'b0, lat);
    runTransfer(1, 1'b0, 8'h50, 32'h0, 0, 1'b0, 32'h11112222, 1'b0, 1, 1'b0, lat);
    req = '0;
    modelLast = 1;

    for (int v = 0; v < 11; v++) begin
      applyStimulus(vecs[v].rq, vecs[v].wr, vecs[v].addr, vecs[v].wdata);
      runTransfer(vecs[v].rq, vecs[v].wr, vecs[v].addr, vecs[v].wdata, vecs[v].waits, vecs[v].serr,
                  vecs[v].expRdata, vecs[v].expErr, 1, 1'b0, lat);
      checkOutput("latency", lat, vecs[v].expLat);
      req[vecs[v].rq] = 1'b0;
      modelLast = vecs[v].rq;
      @(negedge pclk);
      checkOutput("idleDone", 32'(done), 32'd0);
      checkOutput("idlePsel", 32'(psel), 32'd0);
    end

    // A lone requester holding req through done waits one extra cycle.
    applyStimulus(2, 1'b0, 8'h05, 32'h0);
    runTransfer(2, 1'b0, 8'h05, 32'h0, 0, 1'b0, 32'hA5A50005, 1'b0, 1, 1'b0, lat);
    runTransfer(2, 1'b0, 8'h05, 32'h0, 0, 1'b0, 32'hA5A50005, 1'b0, 2, 1'b0, lat);
    req[2] = 1'b0;
    modelLast = 2;

    // Reset in the middle of a wait-stated ACCESS aborts without done.
    applyStimulus(1, 1'b1, 8'h60, 32'h55AA55AA);
    @(negedge pclk);
    pready = 1'b0;
    checkOutput("abortSetupPsel", 32'(psel), 32'd1);
    @(negedge pclk);
    pready = 1'b0;
    checkOutput("abortAccessEnable", 32'(penable), 32'd1);
    #2 presetn = 1'b0;
    #1;
    checkOutput("abortPsel", 32'(psel), 32'd0);
    checkOutput("abortPenable", 32'(penable), 32'd0);
    checkOutput("abortGnt", 32'(gnt), 32'd0);
    checkOutput("abortDone", 32'(done), 32'd0);
    applyStimulus(0, 1'b0, 8'h10, 32'h0);
    applyStimulus(2, 1'b0, 8'h60, 32'h0);
    @(negedge pclk);
    checkOutput("abortHeldDone", 32'(done), 32'd0);
    presetn = 1'b1;
    modelLast = NR - 1;
    runTransfer(0, 1'b0, 8'h10, 32'h0, 0, 1'b0, 32'hDEADBEEF, 1'b0, 1, 1'b0, lat);
    req[0] = 1'b0;
    runTransfer(1, 1'b1, 8'h60, 32'h55AA55AA, 1, 1'b0, 32'h0, 1'b0, 1, 1'b0, lat);
    req[1] = 1'b0;
    runTransfer(2, 1'b0, 8'h60, 32'h0, 0, 1'b0, 32'h55AA55AA, 1'b0, 1, 1'b0, lat);
    req[2] = 1'b0;
    modelLast = 2;

    // Randomized rounds: a set of requesters raises together and is served
    // in cyclic order after the previous winner; some withdraw before grant.
    for (int r = 0; r < 40; r++) begin
      logic [NR-1:0] pending;
      logic          rqWr [NR];
      logic [7:0]    rqAddr [NR];
      logic [31:0]   rqWd [NR];
      int            nIdle;
      int            w;
      int            waits;
      logic          serr;
      logic          toHit;
      nIdle = $urandom_range(1, 2);
      for (int k = 0; k < nIdle; k++) begin
        @(negedge pclk);
        checkOutput("gapPsel", 32'(psel), 32'd0);
        checkOutput("gapDone", 32'(done), 32'd0);
      end
      pending = NR'($urandom_range(1, (1 << NR) - 1));
      for (int i = 0; i < NR; i++) begin
        rqWr[i]   = 1'($urandom);
        rqAddr[i] = 8'($urandom_range(0, 15));
        rqWd[i]   = $urandom;
        if (pending[i]) applyStimulus(i, rqWr[i], rqAddr[i], rqWd[i]);
      end
      while (pending != '0) begin
        if ($countones(pending) > 1 && $urandom_range(0, 5) == 0) begin
          for (int i = 0; i < NR; i++) begin
            if (pending[i] && $countones(pending) > 1 && $urandom_range(0, 1) == 1) begin
              pending[i] = 1'b0;
              req[i]     = 1'b0;
            end
          end
        end
        w = -1;
        for (int k = 1; k <= NR; k++) begin
          if (w < 0 && pending[(modelLast + k) % NR]) w = (modelLast + k) % NR;
        end
        waits = $urandom_range(0, 5);
        serr  = ($urandom_range(0, 3) == 0);
        toHit = (waits >= TO);
        runTransfer(w, rqWr[w], rqAddr[w], rqWd[w], waits, serr,
                    (rqWr[w] || toHit) ? 32'h0 : mem[rqAddr[w]], serr || toHit,
                    1, 1'($urandom), lat);
        req[w]     = 1'b0;
        pending[w] = 1'b0;
        modelLast  = w;
      end
    end

    @(negedge pclk);
    checkOutput("finalPsel", 32'(psel), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/apb_req_arbiter.md
# apb_req_arbiter

Round-robin APB requester arbiter and master sequencer. Shares one APB completer (the 256-word register/memory slave) among NUM_REQ internal requesters. Each request is converted into a compliant SETUP/ACCESS transfer. The block tracks wait states, times out hung transfers, and returns read data and error status to the granted requester.

## Interface
- NUM_REQ, 2: number of requesters, legal range 2..4.
- WIDTH, 32: APB data width.
- ADDR_WIDTH, 8: APB address width.
- TIMEOUT, 15: maximum ACCESS cycles with pready low before forced termination. 0 disables the timeout.
---
- pclk  in  1  APB clock; all logic is on its rising edge.
- presetn  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester request level, held until the matching done.
- req_write  in  NUM_REQ  per-requester direction, 1 = write.
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  NUM_REQ*WIDTH  packed write data; same packing rule.
- gnt  out  NUM_REQ  one-hot, high while the requester's transfer is on the bus.
- done  out  NUM_REQ  one-hot, single-cycle completion pulse.
- rsp_rdata  out  WIDTH  read data, valid with done.
- rsp_err  out  1  error flag, valid with done (pslverr or timeout).
- psel, penable, pwrite  out  1  APB control.
- paddr  out  ADDR_WIDTH  APB address.
- pwdata  out  WIDTH  APB write data.
- prdata  in  WIDTH  APB read data.
- pready, pslverr  in  1  APB completer response.

## Operation
- FSM states: IDLE, SETUP, ACCESS. All outputs are registered.
- IDLE:
  - Eligible requesters are those with req high, excluding any requester whose done is high this cycle.
  - If any requester is eligible, select winner w by round-robin. Search order is last+1, last+2, … mod NUM_REQ.
  - Latch req_write/req_addr/req_wdata of w into pwrite/paddr/pwdata.
  - Set gnt[w]=1 and psel=1; next state is SETUP. Set last=w.
- SETUP: exactly one cycle. Set penable=1; next state is ACCESS. paddr/pwrite/pwdata stay stable.
- ACCESS, pready=1:
  - Transfer completes.
  - On a read, rsp_rdata<=prdata; on a write, rsp_rdata<=0.
  - rsp_err<=pslverr.
  - done[w]<=1; psel, penable, and gnt cleared; next state is IDLE.
- ACCESS, pready=0:
  - The wait counter increments.
  - If TIMEOUT≠0 and the counter reaches TIMEOUT, the transfer terminates as above with rsp_err=1 and rsp_rdata=0.
- Wait counter: $clog2(TIMEOUT+1) bits, saturating. Cleared on entry to SETUP.
- done, rsp_rdata, and rsp_err are valid for the single IDLE cycle after completion. rsp_rdata/rsp_err hold until the next completion; done is a pulse.
- Requester inputs are sampled only in the arbitration cycle. Changes after gnt do not affect the bus.
- req dropped before grant: the request is withdrawn silently. req dropped after grant: the transfer still completes and done still pulses.

## Timing
- Reset (asynchronous, immediate) clears:
  - state to IDLE;
  - psel, penable, pwrite, gnt, done, rsp_err to 0;
  - paddr, pwdata, rsp_rdata to 0;
  - wait counter to 0;
  - last to NUM_REQ-1, so requester 0 wins first.
- Reset mid-transfer aborts the transfer: psel drops asynchronously and no done is issued.
- Zero-wait transfer: req seen at edge 0 → psel at edge 1 (SETUP) → penable at edge 2 (ACCESS) → pready sampled at edge 3 → done high after edge 3. Latency is 3 cycles from req to done.
- Each cycle of pready low in ACCESS adds one cycle.
- At least one IDLE cycle separates consecutive transfers: psel is never high on two consecutive transfers without an idle cycle between.
- Simultaneous requests: exactly one grant per arbitration. The winner cannot win again while another requester is waiting.
- The masking on done prevents a requester that still holds req during its done cycle from being re-granted. That requester becomes eligible again on the following cycle.

## Test plan
- Single write then read: requester 0 writes addr 0x10 = 0xDEADBEEF, then reads addr 0x10.
  - Expect psel/penable pattern 1/0 then 1/1.
  - Expect done[0] 3 cycles after req.
  - Expect rsp_rdata = 0xDEADBEEF and rsp_err = 0.
- Contention: req = 2'b11 held continuously with NUM_REQ=2.
  - Expect grants alternating 0, 1, 0, 1.
  - Expect exactly one IDLE cycle between transfers.
  - Expect gnt always one-hot.
- Wait states: completer holds pready low for 2 ACCESS cycles.
  - Expect penable high for 3 cycles and done 5 cycles after req.
  - Expect paddr/pwdata stable throughout.
- Timeout: TIMEOUT=4, pready tied low.
  - Expect ACCESS to last 4 cycles, then done with rsp_err = 1 and rsp_rdata = 0.
  - Expect psel low the following cycle.
- Slave error: pslverr = 1 with pready on a read of 0x20.
  - Expect rsp_err = 1 and rsp_rdata = prdata.
  - Expect the next transfer to return rsp_err = 0.
- Reset during ACCESS: assert presetn low mid-wait.
  - Expect psel, penable, gnt, and done at 0 immediately, with no done pulse.
  - After release, expect requester 0 granted first.
